branch_history_table: RTL and testbench
=======================================

BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset. Port names are clock_i and reset_n_i.
REQ-002 Parameter ENTRIES, default 64: number of table entries; SHALL be a power of two, minimum 4.
REQ-003 Parameter TAG_WIDTH, default 8: stored tag bits per entry, minimum 1.
REQ-004 Parameter COUNTER_WIDTH, default 2: saturating counter width, minimum 1.
REQ-005 Parameter COUNT_WIDTH, default 16: width of the misprediction statistics counter.
REQ-006 clock_i  input  1  rising-edge clock.
REQ-007 reset_n_i  input  1  asynchronous active-low reset.
REQ-008 lookup_valid_i  input  1  fetch-stage prediction request.
REQ-009 lookup_address_i  input  32  PC of the fetched instruction.
REQ-010 predict_valid_o  output  1  a prediction result is presented this cycle.
REQ-011 predict_hit_o  output  1  the looked-up entry was valid and its tag matched.
REQ-012 predict_taken_o  output  1  predicted taken.
REQ-013 update_valid_i  input  1  a branch resolved in the memory-access stage.
REQ-014 update_address_i  input  32  PC of the resolved branch.
REQ-015 update_taken_i  input  1  actual branch outcome.
REQ-016 update_mispredicted_i  input  1  the resolved branch was mispredicted; qualified by update_valid_i.
REQ-017 invalidate_i  input  1  clear all entries (context switch or interrupt entry).
REQ-018 mispredict_count_o  output  COUNT_WIDTH  saturating count of mispredictions.

Function
REQ-019 Index SHALL be address[IDX+1:2] with IDX = log2(ENTRIES). Tag SHALL be address[IDX+TAG_WIDTH+1:IDX+2]. Bits [1:0] SHALL be ignored.
REQ-020 Each entry SHALL hold a valid bit, a tag and a counter.
REQ-021 Lookup latency SHALL be 1 cycle. predict_valid_o in cycle N+1 SHALL equal lookup_valid_i in cycle N, and the other result outputs SHALL reflect table state sampled at the edge ending cycle N.
REQ-022 predict_hit_o SHALL be the entry's valid bit ANDed with tag equality.
REQ-023 predict_taken_o SHALL be the hit condition ANDed with the counter MSB. A miss SHALL predict not-taken.
REQ-024 When predict_valid_o=0, predict_hit_o and predict_taken_o SHALL be 0.
REQ-025 On an update hit, the counter SHALL increment if taken and decrement if not taken, saturating at all-ones and at zero.
REQ-026 On an update miss (invalid entry or tag mismatch), the entry SHALL be allocated:
- valid=1 and the new tag written;
- counter = 1 followed by zeros (weakly taken) if taken, or 0 followed by ones (weakly not-taken) if not taken;
- any previous occupant is overwritten.
REQ-027 With COUNTER_WIDTH=1, allocation SHALL write counter = update_taken_i.
REQ-028 Lookup and update to the same index in the same cycle SHALL be read-before-write: the lookup returns the pre-update entry.
REQ-029 invalidate_i SHALL clear every valid bit at the next edge. Counters and tags are don't-care.
REQ-030 invalidate_i and update_valid_i in the same cycle SHALL leave the table fully invalid (invalidate wins).
REQ-031 A lookup in the same cycle as invalidate_i SHALL return the pre-invalidate state.
REQ-032 mispredict_count_o SHALL increment by 1 on each cycle where update_valid_i and update_mispredicted_i are both 1, and SHALL saturate at all-ones. invalidate_i SHALL NOT clear it.
REQ-033 Table storage SHALL be inferable as registers. Only valid bits need reset, in addition to the output registers.

Reset
REQ-034 While reset_n_i=0, regardless of clock, the following SHALL be 0: all valid bits, predict_valid_o, predict_hit_o, predict_taken_o and mispredict_count_o.
REQ-035 A lookup or update in flight when reset asserts SHALL be discarded.
REQ-036 The first lookup accepted after reset release SHALL miss.

Verification
Defaults apply: ENTRIES=64, TAG_WIDTH=8, COUNTER_WIDTH=2.
REQ-037 Reset, then lookup 0x100 -> next cycle: predict_valid_o=1, predict_hit_o=0, predict_taken_o=0.
REQ-038 Update 0x100 taken, then lookup 0x100 -> hit=1, taken=1 (counter 2'b10).
- Three more taken updates -> counter holds 2'b11.
- Then two not-taken updates -> counter 2'b01, taken=0.
REQ-039 0x100 allocated; lookup 0x200 (same index 0, tag 0x02 vs 0x01) -> hit=0.
- Update 0x200 not-taken, then lookup 0x100 -> hit=0; lookup 0x200 -> hit=1, taken=0.
REQ-040 Same cycle: lookup 0x100 and not-taken update 0x100 on counter 2'b10 -> result taken=1. A lookup in the following cycle -> taken=0.
REQ-041 Same cycle: invalidate_i and update 0x300 taken -> a subsequent lookup of 0x300 misses.
- Mispredict count from prior updates is preserved.
REQ-042 Assert reset_n_i mid-cycle between edges with mispredict_count_o=5 and entries valid -> outputs go to 0 immediately.
- After release, lookup 0x100 -> hit=0.

Source files
------------

// File: rtl/branch_history_table.sv
// Direct-mapped branch history table: each entry is a valid bit, a tag and a
// saturating taken/not-taken counter. Lookup results are registered (1-cycle
// latency); updates from the memory-access stage train or allocate entries.
module branch_history_table #(
    parameter int ENTRIES       = 64,
    parameter int TAG_WIDTH     = 8,
    parameter int COUNTER_WIDTH = 2,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   lookup_valid_i,
    input  logic [31:0]            lookup_address_i,
    output logic                   predict_valid_o,
    output logic                   predict_hit_o,
    output logic                   predict_taken_o,
    input  logic                   update_valid_i,
    input  logic [31:0]            update_address_i,
    input  logic                   update_taken_i,
    input  logic                   update_mispredicted_i,
    input  logic                   invalidate_i,
    output logic [COUNT_WIDTH-1:0] mispredict_count_o
);
    localparam int IDX = $clog2(ENTRIES);

    // Allocation values: weakly taken is 10..0, weakly not-taken is 01..1.
    // With a 1-bit counter these collapse to 1 and 0 respectively.
    localparam logic [COUNTER_WIDTH-1:0] WEAK_TAKEN     = COUNTER_WIDTH'(1) << (COUNTER_WIDTH - 1);
    localparam logic [COUNTER_WIDTH-1:0] WEAK_NOT_TAKEN = WEAK_TAKEN - COUNTER_WIDTH'(1);

    typedef logic [IDX-1:0]       idx_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;

    typedef struct packed {
        tag_t                     tag;
        logic [COUNTER_WIDTH-1:0] ctr;
    } entry_t;

    logic [ENTRIES-1:0] valid_q;
    entry_t             table_q [ENTRIES];

    idx_t   lookup_idx, update_idx;
    tag_t   lookup_tag, update_tag;
    entry_t lookup_entry, update_entry;
    logic   lookup_hit, update_hit;
    logic [COUNTER_WIDTH-1:0] ctr_next;

    // Address bits outside index/tag (including [1:0]) are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{lookup_address_i, update_address_i};

    assign lookup_idx   = lookup_address_i[IDX+1:2];
    assign lookup_tag   = lookup_address_i[IDX+TAG_WIDTH+1:IDX+2];
    assign update_idx   = update_address_i[IDX+1:2];
    assign update_tag   = update_address_i[IDX+TAG_WIDTH+1:IDX+2];
    assign lookup_entry = table_q[lookup_idx];
    assign update_entry = table_q[update_idx];
    assign lookup_hit   = valid_q[lookup_idx] && (lookup_entry.tag == lookup_tag);
    assign update_hit   = valid_q[update_idx] && (update_entry.tag == update_tag);

    // Counter value written by an update: saturating train on hit, weak allocate on miss.
    always_comb begin
        ctr_next = update_entry.ctr;
        if (!update_hit)
            ctr_next = update_taken_i ? WEAK_TAKEN : WEAK_NOT_TAKEN;
        else if (update_taken_i && update_entry.ctr != '1)
            ctr_next = update_entry.ctr + COUNTER_WIDTH'(1);
        else if (!update_taken_i && update_entry.ctr != '0)
            ctr_next = update_entry.ctr - COUNTER_WIDTH'(1);
    end

    // Registered prediction; reads the pre-edge table so same-cycle updates are not visible.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            predict_valid_o <= 1'b0;
            predict_hit_o   <= 1'b0;
            predict_taken_o <= 1'b0;
        end else begin
            predict_valid_o <= lookup_valid_i;
            predict_hit_o   <= lookup_valid_i && lookup_hit;
            predict_taken_o <= lookup_valid_i && lookup_hit && lookup_entry.ctr[COUNTER_WIDTH-1];
        end
    end

    // Valid bits; invalidate takes priority over a same-cycle allocation.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)
            valid_q <= '0;
        else if (invalidate_i)
            valid_q <= '0;
        else if (update_valid_i)
            valid_q[update_idx] <= 1'b1;
    end

    // Tag/counter storage needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clock_i) begin
        if (update_valid_i)
            table_q[update_idx] <= '{tag: update_tag, ctr: ctr_next};
    end

    // Saturating misprediction statistic; survives invalidate, cleared only by reset.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)
            mispredict_count_o <= '0;
        else if (update_valid_i && update_mispredicted_i && mispredict_count_o != '1)
            mispredict_count_o <= mispredict_count_o + COUNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_branch_history_table.sv
// Bench for branch_history_table: directed scenarios with literal expectations,
// then randomized traffic, all checked against a table model kept as plain arrays.
module tb_branch_history_table;
    logic        clock_i = 1'b0;
    logic        reset_n_i = 1'b1;
    logic        lookup_valid_i = 1'b0;
    logic [31:0] lookup_address_i = '0;
    logic        predict_valid_o, predict_hit_o, predict_taken_o;
    logic        update_valid_i = 1'b0;
    logic [31:0] update_address_i = '0;
    logic        update_taken_i = 1'b0;
    logic        update_mispredicted_i = 1'b0;
    logic        invalidate_i = 1'b0;
    logic [15:0] mispredict_count_o;

    int checks = 0;
    int errors = 0;

    // Model state: 64 entries, 2-bit counters held as small integers 0..3.
    bit mvalid [64];
    int mtag   [64];
    int mctr   [64];
    int mcount = 0;

    branch_history_table dut (
        .clock_i               (clock_i),
        .reset_n_i             (reset_n_i),
        .lookup_valid_i        (lookup_valid_i),
        .lookup_address_i      (lookup_address_i),
        .predict_valid_o       (predict_valid_o),
        .predict_hit_o         (predict_hit_o),
        .predict_taken_o       (predict_taken_o),
        .update_valid_i        (update_valid_i),
        .update_address_i      (update_address_i),
        .update_taken_i        (update_taken_i),
        .update_mispredicted_i (update_mispredicted_i),
        .invalidate_i          (invalidate_i),
        .mispredict_count_o    (mispredict_count_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) & 32'd63);
    endfunction

    function automatic int tag_of(input logic [31:0] a);
        return int'((a >> 8) & 32'd255);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        mcount = 0;
    endtask

    // One clock cycle: drive inputs, advance the model, then compare every output.
    task automatic cycle(input bit lv, input logic [31:0] la, input bit uv,
                         input logic [31:0] ua, input bit ut, input bit um, input bit inv);
        bit eh, et;
        int i, j;
        @(negedge clock_i);
        lookup_valid_i = lv; lookup_address_i = la;
        update_valid_i = uv; update_address_i = ua;
        update_taken_i = ut; update_mispredicted_i = um;
        invalidate_i = inv;
        i  = idx_of(la);
        eh = lv && mvalid[i] && (mtag[i] == tag_of(la));
        et = eh && (mctr[i] >= 2);
        if (uv && um && mcount < 65535) mcount++;
        if (inv) begin
            for (int k = 0; k < 64; k++) mvalid[k] = 1'b0;
        end else if (uv) begin
            j = idx_of(ua);
            if (mvalid[j] && mtag[j] == tag_of(ua)) begin
                if (ut) mctr[j] = (mctr[j] < 3) ? mctr[j] + 1 : 3;
                else    mctr[j] = (mctr[j] > 0) ? mctr[j] - 1 : 0;
            end else begin
                mvalid[j] = 1'b1;
                mtag[j]   = tag_of(ua);
                mctr[j]   = ut ? 2 : 1;
            end
        end
        @(posedge clock_i);
        #1;
        chk("predict_valid", int'(predict_valid_o), int'(lv));
        chk("predict_hit", int'(predict_hit_o), int'(eh));
        chk("predict_taken", int'(predict_taken_o), int'(et));
        chk("mispredict_count", int'(mispredict_count_o), mcount);
        lookup_valid_i = 1'b0; update_valid_i = 1'b0; invalidate_i = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a);
        cycle(1'b1, a, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [31:0] a, input bit t, input bit m);
        cycle(1'b0, 32'h0, 1'b1, a, t, m, 1'b0);
    endtask

    task automatic lit(input string name, input int h, input int t);
        chk({name, "_valid"}, int'(predict_valid_o), 1);
        chk({name, "_hit"}, int'(predict_hit_o), h);
        chk({name, "_taken"}, int'(predict_taken_o), t);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom() & 32'hFFFF_0000;
        a = a | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        return a;
    endfunction

    initial begin
        // Reset: outputs must be zero with no clock edge needed.
        #1 reset_n_i = 1'b0;
        model_clear();
        #1;
        chk("rst_predict_valid", int'(predict_valid_o), 0);
        chk("rst_predict_hit", int'(predict_hit_o), 0);
        chk("rst_predict_taken", int'(predict_taken_o), 0);
        chk("rst_count", int'(mispredict_count_o), 0);
        repeat (2) @(posedge clock_i);
        @(negedge clock_i) reset_n_i = 1'b1;

        // First lookup after reset misses.
        lookup(32'h100);                 lit("first", 0, 0);
        // Allocate weakly taken, then saturate up and train down.
        update(32'h100, 1'b1, 1'b1);
        lookup(32'h100);                 lit("alloc_t", 1, 1);
        repeat (3) update(32'h100, 1'b1, 1'b0);
        lookup(32'h100);                 lit("sat_hi", 1, 1);
        repeat (2) update(32'h100, 1'b0, 1'b0);
        lookup(32'h100);                 lit("down2", 1, 0);
        // Tag conflict at index 0.
        lookup(32'h200);                 lit("conflict", 0, 0);
        update(32'h200, 1'b0, 1'b1);
        lookup(32'h100);                 lit("evicted", 0, 0);
        lookup(32'h200);                 lit("alloc_nt", 1, 0);
        // Read-before-write on the same index.
        update(32'h100, 1'b1, 1'b0);
        cycle(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        lit("rbw_old", 1, 1);
        lookup(32'h100);                 lit("rbw_new", 1, 0);
        // Invalidate wins over same-cycle update; count keeps counting.
        cycle(1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
        lit("inv_lookup_old", 1, 0);
        lookup(32'h300);                 lit("inv_miss", 0, 0);
        chk("inv_count_kept", int'(mispredict_count_o), 4);
        // Bring count to 5 with a live hit on the outputs, then reset mid-cycle.
        update(32'h100, 1'b1, 1'b1);
        lookup(32'h100);                 lit("pre_rst", 1, 1);
        chk("pre_rst_count", int'(mispredict_count_o), 5);
        #2 reset_n_i = 1'b0;
        #1;
        model_clear();
        chk("mid_rst_valid", int'(predict_valid_o), 0);
        chk("mid_rst_hit", int'(predict_hit_o), 0);
        chk("mid_rst_taken", int'(predict_taken_o), 0);
        chk("mid_rst_count", int'(mispredict_count_o), 0);
        repeat (2) @(posedge clock_i);
        @(negedge clock_i) reset_n_i = 1'b1;
        lookup(32'h100);                 lit("post_rst", 0, 0);

        // Randomized traffic on a small address window so hits and conflicts are frequent.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, rnd_addr(),
                  $urandom_range(0, 1) == 1, rnd_addr(),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
